key_sched_seq: RTL and testbench



---
 rtl/key_sched_seq.sv | 204 ++++++++++++++++++++
 tb/tb_key_sched_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/key_sched_seq.sv
`default_nettype none
// ============================================================================
// key_sched_seq : iterative AES-128 key schedule, one round key per clock,
//                 11-entry round-key table behind a registered read port.
// Optional macro : KEY_SCHED_ZEROIZE_EN (adds zeroize input)
// Revision       : 1.0
// ============================================================================

module sbox_LUT (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = C_SBOX[11'd2047 - {a_i, 3'b000} -: 8];
endmodule

module key_sched_seq #(
  parameter int NUM_RK = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] aes_key,
  output logic         busy,
  output logic         done,
  output logic [3:0]   rk_avail,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         rk_data_ok
`ifdef KEY_SCHED_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  localparam logic [3:0] C_EMPTY = 4'hF;
  localparam logic [3:0] C_LAST  = 4'(NUM_RK - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     avail_q, avail_d;
  logic [127:0]   work_q, work_d;
  logic           done_q, done_d;
  logic [127:0]   rd_data_q;
  logic           rd_ok_q;
  logic [127:0]   table_q [NUM_RK];

  logic           wr_en;
  logic [3:0]     wr_idx;
  logic [127:0]   wr_data;
  logic           accept;
  logic           clr;
  logic           rd_hit;
  logic [7:0]     rcon;
  logic [31:0]    rot_w, sub_w, t_w;
  logic [31:0]    n3, n2, n1, n0;
  logic [127:0]   f_out;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign clr = zeroize;
`else
  assign clr = 1'b0;
`endif

  assign key_ready  = ~rst & ~clr & (state_q != S_EXPAND);
  assign accept     = key_valid & key_ready;
  assign busy       = (state_q == S_EXPAND);
  assign done       = done_q;
  assign rk_avail   = avail_q;
  assign rk_data    = rd_data_q;
  assign rk_data_ok = rd_ok_q;

  always_comb begin
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Single round-function instance, fed from the working register.
  assign rot_w = {work_q[23:0], work_q[31:24]};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_sbox
      sbox_LUT u_sbox (
        .a_i (rot_w[8*g +: 8]),
        .s_o (sub_w[8*g +: 8])
      );
    end
  endgenerate

  assign t_w   = sub_w ^ {rcon, 24'h000000};
  assign n3    = work_q[127:96] ^ t_w;
  assign n2    = n3 ^ work_q[95:64];
  assign n1    = n2 ^ work_q[63:32];
  assign n0    = n1 ^ work_q[31:0];
  assign f_out = {n3, n2, n1, n0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    avail_d = avail_q;
    work_d  = work_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = f_out;
    case (state_q)
      S_IDLE, S_READY: begin
        if (accept) begin
          state_d = S_EXPAND;
          cnt_d   = 4'd1;
          avail_d = 4'd0;
          work_d  = aes_key;
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_data = aes_key;
        end
      end
      S_EXPAND: begin
        wr_en   = 1'b1;
        avail_d = cnt_q;
        work_d  = f_out;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == C_LAST) begin
          state_d = S_READY;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read qualification uses the pre-edge rk_avail, so same-cycle writes are not bypassed.
  assign rd_hit = (avail_q != C_EMPTY) && (rk_addr <= avail_q) && (rk_addr <= C_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      avail_q   <= C_EMPTY;
      work_q    <= '0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      avail_q   <= avail_d;
      work_q    <= work_d;
      done_q    <= done_d;
      rd_data_q <= rd_hit ? table_q[rk_addr] : '0;
      rd_ok_q   <= rd_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && clr) begin
      for (int i = 0; i < NUM_RK; i++) begin
        table_q[i] <= '0;
      end
    end else if (!rst && wr_en) begin
      table_q[wr_idx] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_sched_seq.sv
`default_nettype none
// tb_key_sched_seq : directed vectors for key_sched_seq; stimulus queues the
// expected post-edge outputs, a monitor pops and compares them each cycle.
module tb_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [127:0] aes_key = '0;
  logic [3:0]   rk_addr = '0;
  logic         key_ready, busy, done, rk_data_ok;
  logic [3:0]   rk_avail;
  logic [127:0] rk_data;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  key_sched_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .aes_key    (aes_key),
    .busy       (busy),
    .done       (done),
    .rk_avail   (rk_avail),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .rk_data_ok (rk_data_ok)
`ifdef KEY_SCHED_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  typedef struct {
    string        n;
    bit           crd;
    logic [127:0] d;
    bit           ok;
    bit           rdy;
    bit           bsy;
    bit           dn;
    logic [3:0]   av;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] RKA [11];
  logic [127:0] RKZ1, RKZ10;

  task automatic cmp(input string n, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Drive this cycle's address, queue the outputs expected after the next edge.
  task automatic step(input string n, input logic [3:0] a, input bit crd,
                      input logic [127:0] d, input bit ok, input bit rdy,
                      input bit bsy, input bit dn, input logic [3:0] av);
    exp_t e;
    e.n = n; e.crd = crd; e.d = d; e.ok = ok;
    e.rdy = rdy; e.bsy = bsy; e.dn = dn; e.av = av;
    rk_addr = a;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.crd) begin
          cmp({e.n, ".data"}, rk_data, e.d);
          cmp({e.n, ".ok"}, {127'd0, rk_data_ok}, {127'd0, e.ok});
        end
        cmp({e.n, ".ready"}, {127'd0, key_ready}, {127'd0, e.rdy});
        cmp({e.n, ".busy"}, {127'd0, busy}, {127'd0, e.bsy});
        cmp({e.n, ".done"}, {127'd0, done}, {127'd0, e.dn});
        cmp({e.n, ".avail"}, {124'd0, rk_avail}, {124'd0, e.av});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RKA[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    RKA[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    RKA[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    RKA[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    RKA[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    RKA[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    RKA[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    RKA[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    RKA[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    RKA[9]  = 128'hac7766f319fadc2128d12941575c006e;
    RKA[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    RKZ1    = 128'h62636363626363636263636362636363;
    RKZ10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    @(negedge clk);
    rst = 1'b1;
    step("rst0", 4'd0, 1, '0, 0, 0, 0, 0, 4'hF);
    step("rst1", 4'd0, 1, '0, 0, 0, 0, 0, 4'hF);
    rst = 1'b0;
    step("idle", 4'd0, 1, '0, 0, 1, 0, 0, 4'hF);

    // FIPS-197 key; junk key held valid during expansion must be ignored.
    key_valid = 1'b1;
    aes_key   = RKA[0];
    step("accA", 4'd5, 1, '0, 0, 0, 1, 0, 4'd0);
    aes_key = '1;
    for (int j = 1; j <= 10; j++) begin
      if (j == 4) key_valid = 1'b0;
      step($sformatf("expA%0d", j), 4'd5, 1, (j >= 6) ? RKA[5] : 128'd0, (j >= 6),
           (j == 10), (j < 10), (j == 10), 4'(j));
    end
    for (int i = 0; i <= 10; i++) begin
      step($sformatf("rdA%0d", i), 4'(i), 1, RKA[i], 1, 1, 0, 0, 4'd10);
    end
    step("rd12", 4'd12, 1, '0, 0, 1, 0, 0, 4'd10);
    step("rd15", 4'd15, 1, '0, 0, 1, 0, 0, 4'd10);

    // All-zero key accepted from READY; same-edge read sees the old entry 10.
    key_valid = 1'b1;
    aes_key   = '0;
    step("accZ", 4'd10, 1, RKA[10], 1, 0, 1, 0, 4'd0);
    key_valid = 1'b0;
    step("staleZ", 4'd10, 1, '0, 0, 0, 1, 0, 4'd1);
    for (int j = 2; j <= 10; j++) begin
      step($sformatf("expZ%0d", j), 4'd1, 1, RKZ1, 1, (j == 10), (j < 10), (j == 10), 4'(j));
    end
    step("rdZ10", 4'd10, 1, RKZ10, 1, 1, 0, 0, 4'd10);

    // Reset in the fourth expansion cycle.
    key_valid = 1'b1;
    aes_key   = RKA[0];
    step("accR", 4'd0, 1, '0, 1, 0, 1, 0, 4'd0);
    key_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step($sformatf("expR%0d", j), 4'd0, 1, RKA[0], 1, 0, 1, 0, 4'(j));
    end
    rst = 1'b1;
    step("rstE", 4'd0, 1, '0, 0, 0, 0, 0, 4'hF);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step($sformatf("postR%0d", k), 4'd0, 1, '0, 0, 1, 0, 0, 4'hF);
    end

`ifdef KEY_SCHED_ZEROIZE_EN
    key_valid = 1'b1;
    aes_key   = RKA[0];
    step("accQ", 4'd0, 1, '0, 0, 0, 1, 0, 4'd0);
    key_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step($sformatf("expQ%0d", j), 4'd0, 1, RKA[0], 1, (j == 10), (j < 10), (j == 10), 4'(j));
    end
    zeroize = 1'b1;
    step("zero", 4'd10, 1, '0, 0, 0, 0, 0, 4'hF);
    zeroize   = 1'b0;
    key_valid = 1'b1;
    step("accQ2", 4'd10, 1, '0, 0, 0, 1, 0, 4'd0);
    key_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step($sformatf("expQ2_%0d", j), 4'd10, 1, '0, 0, (j == 10), (j < 10), (j == 10), 4'(j));
    end
    step("rdQ10", 4'd10, 1, RKA[10], 1, 1, 0, 0, 4'd10);
`endif

    rk_addr = 4'd0;
    @(posedge clk);
    #2;
    cmp("drain", 128'(sbq.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
